// File: rtl/tmds_link_ctrl.sv
// rtl/tmds_link_ctrl.sv - TMDS serializer bring-up, warm-up and lane hand-off sequencer
module tmds_link_ctrl #(
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned WARMUP   = 64,
  parameter logic [9:0]  CTL0     = 10'b1101010100
) (
  input  logic       divclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       resync,
  input  logic       de,
  input  logic [9:0] enc_word0,
  input  logic [9:0] enc_word1,
  input  logic [9:0] enc_word2,
  output logic       ser_rst,
  output logic [9:0] tx_word0,
  output logic [9:0] tx_word1,
  output logic [9:0] tx_word2,
  output logic       link_up,
  output logic [7:0] lock_lost_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SER_RST = 2'd1,
    ST_WARMUP  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        lost_evt;

  always_ff @(posedge divclk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Lock loss outranks resync, which outranks the normal sequence.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lost_evt = 1'b0;
    if (state != ST_IDLE && !pll_locked) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      lost_evt = 1'b1;
    end else if ((state == ST_WARMUP || state == ST_RUN) && resync) begin
      state_n = ST_SER_RST;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pll_locked) begin
            state_n = ST_SER_RST;
            cnt_n   = '0;
          end
        end
        ST_SER_RST: begin
          if (cnt == HOLD_LAST) begin
            state_n = ST_WARMUP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_WARMUP: begin
          // Hold at the last count until blanking so video starts on a boundary.
          if (cnt == WARM_LAST) begin
            if (!de) begin
              state_n = ST_RUN;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ser_rst = (state == ST_IDLE) || (state == ST_SER_RST);
  assign link_up = (state == ST_RUN);

  always_ff @(posedge divclk) begin
    if (rst) begin
      lock_lost_cnt <= '0;
    end else if (lost_evt && lock_lost_cnt != 8'hFF) begin
      lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

  // One select for all lanes keeps them from ever carrying mixed content.
  always_ff @(posedge divclk) begin
    if (rst || state != ST_RUN) begin
      tx_word0 <= CTL0;
      tx_word1 <= CTL0;
      tx_word2 <= CTL0;
    end else begin
      tx_word0 <= enc_word0;
      tx_word1 <= enc_word1;
      tx_word2 <= enc_word2;
    end
  end

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// tb/tb_tmds_link_ctrl.sv - self-checking bench for tmds_link_ctrl
module tb_tmds_link_ctrl;

  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned WARMUP   = 8;
  localparam logic [9:0]  CTL0     = 10'h354;

  localparam int P_IDLE = 0;
  localparam int P_RST  = 1;
  localparam int P_WARM = 2;
  localparam int P_RUN  = 3;

  logic       divclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       resync = 1'b0;
  logic       de = 1'b0;
  logic [9:0] enc [3];
  logic       ser_rst;
  logic [9:0] tx_word0, tx_word1, tx_word2;
  logic       link_up;
  logic [7:0] lock_lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: phase plus number of cycles already spent in it.
  int         m_phase   = P_IDLE;
  int         m_elapsed = 0;
  int         m_lost    = 0;
  logic [9:0] m_tx [3];

  tmds_link_ctrl #(.RST_HOLD(RST_HOLD), .WARMUP(WARMUP), .CTL0(CTL0)) dut (
    .divclk       (divclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .resync       (resync),
    .de           (de),
    .enc_word0    (enc[0]),
    .enc_word1    (enc[1]),
    .enc_word2    (enc[2]),
    .ser_rst      (ser_rst),
    .tx_word0     (tx_word0),
    .tx_word1     (tx_word1),
    .tx_word2     (tx_word2),
    .link_up      (link_up),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 divclk = ~divclk;

  task automatic step();
    int         np, ne, nl;
    logic [9:0] nt [3];
    np = m_phase;
    ne = m_elapsed;
    nl = m_lost;
    for (int i = 0; i < 3; i++) nt[i] = (m_phase == P_RUN) ? enc[i] : CTL0;
    if (rst) begin
      np = P_IDLE; ne = 0; nl = 0;
      for (int i = 0; i < 3; i++) nt[i] = CTL0;
    end else if (m_phase != P_IDLE && !pll_locked) begin
      np = P_IDLE; ne = 0;
      nl = (m_lost < 255) ? m_lost + 1 : 255;
    end else if ((m_phase == P_WARM || m_phase == P_RUN) && resync) begin
      np = P_RST; ne = 1;
    end else if (m_phase == P_IDLE) begin
      if (pll_locked) begin np = P_RST; ne = 1; end
    end else if (m_phase == P_RST) begin
      if (m_elapsed >= int'(RST_HOLD)) begin np = P_WARM; ne = 1; end
      else ne = m_elapsed + 1;
    end else if (m_phase == P_WARM) begin
      if (m_elapsed >= int'(WARMUP) && !de) begin np = P_RUN; ne = 1; end
      else ne = m_elapsed + 1;
    end
    @(posedge divclk);
    #1;
    m_phase = np; m_elapsed = ne; m_lost = nl;
    for (int i = 0; i < 3; i++) m_tx[i] = nt[i];
  endtask

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; resync = 1'b0; de = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic bring_up(input int max_cycles);
    int g = 0;
    pll_locked = 1'b1; de = 1'b0; resync = 1'b0;
    while (link_up !== 1'b1 && g < max_cycles) begin
      step();
      g++;
    end
    n_checks++;
    if (link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL bring_up_timeout: link_up=%b after %0d cycles, required 1", link_up, g);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) enc[i] = 10'(i + 1);
    do_reset();
    n_checks += 6;
    if (ser_rst !== 1'b1) begin n_fail++; $display("FAIL reset_ser_rst: got %b required 1", ser_rst); end
    if (link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link_up: got %b required 0", link_up); end
    if (tx_word0 !== CTL0) begin n_fail++; $display("FAIL reset_tx0: got %h required %h", tx_word0, CTL0); end
    if (tx_word1 !== CTL0) begin n_fail++; $display("FAIL reset_tx1: got %h required %h", tx_word1, CTL0); end
    if (tx_word2 !== CTL0) begin n_fail++; $display("FAIL reset_tx2: got %h required %h", tx_word2, CTL0); end
    if (lock_lost_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lost_cnt: got %0d required 0", lock_lost_cnt); end
  endtask

  task automatic test_bringup();
    int n = 0, first_low = -1, rise = -1;
    logic [9:0] sent [3];
    do_reset();
    for (int i = 0; i < 10; i++) step();
    pll_locked = 1'b1;
    while (rise < 0 && n < 100) begin
      for (int i = 0; i < 3; i++) enc[i] = 10'($urandom);
      step();
      n++;
      if (first_low < 0 && ser_rst === 1'b0) first_low = n;
      if (link_up === 1'b1) rise = n;
      n_checks++;
      if (rise < 0 && (tx_word0 !== CTL0 || tx_word1 !== CTL0 || tx_word2 !== CTL0)) begin
        n_fail++;
        $display("FAIL bringup_ctl0: cycle %0d tx=%h/%h/%h required %h", n, tx_word0, tx_word1, tx_word2, CTL0);
      end
    end
    n_checks += 2;
    if (first_low != int'(RST_HOLD) + 1) begin
      n_fail++; $display("FAIL bringup_ser_rst_fall: cycle %0d required %0d", first_low, RST_HOLD + 1);
    end
    if (rise != int'(RST_HOLD + WARMUP) + 1) begin
      n_fail++; $display("FAIL bringup_link_up_rise: cycle %0d required %0d", rise, RST_HOLD + WARMUP + 1);
    end
    for (int i = 0; i < 3; i++) begin
      enc[i] = 10'($urandom);
      sent[i] = enc[i];
    end
    step();
    n_checks++;
    if (tx_word0 !== sent[0] || tx_word1 !== sent[1] || tx_word2 !== sent[2]) begin
      n_fail++;
      $display("FAIL bringup_first_word: tx=%h/%h/%h required %h/%h/%h",
               tx_word0, tx_word1, tx_word2, sent[0], sent[1], sent[2]);
    end
  endtask

  task automatic test_de_extend();
    int n = 0, rise = -1;
    do_reset();
    pll_locked = 1'b1;
    while (rise < 0 && n < 100) begin
      de = (n < 16);
      for (int i = 0; i < 3; i++) enc[i] = 10'($urandom);
      step();
      n++;
      if (link_up === 1'b1) rise = n;
      n_checks++;
      if (tx_word0 !== CTL0 || tx_word1 !== CTL0 || tx_word2 !== CTL0) begin
        n_fail++;
        $display("FAIL de_extend_ctl0: cycle %0d tx=%h/%h/%h required %h", n, tx_word0, tx_word1, tx_word2, CTL0);
      end
    end
    de = 1'b0;
    n_checks++;
    if (rise != 17) begin n_fail++; $display("FAIL de_extend_rise: cycle %0d required 17", rise); end
  endtask

  task automatic test_lock_loss();
    int n = 0;
    do_reset();
    bring_up(100);
    pll_locked = 1'b0;
    step();
    n_checks += 3;
    if (link_up !== 1'b0) begin n_fail++; $display("FAIL lockloss_link_up: got %b required 0", link_up); end
    if (ser_rst !== 1'b1) begin n_fail++; $display("FAIL lockloss_ser_rst: got %b required 1", ser_rst); end
    if (lock_lost_cnt !== 8'd1) begin n_fail++; $display("FAIL lockloss_cnt: got %0d required 1", lock_lost_cnt); end
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) enc[i] = 10'($urandom);
    step();
    n++;
    n_checks++;
    if (tx_word0 !== CTL0 || tx_word1 !== CTL0 || tx_word2 !== CTL0) begin
      n_fail++; $display("FAIL lockloss_ctl0: tx=%h/%h/%h required %h", tx_word0, tx_word1, tx_word2, CTL0);
    end
    while (link_up !== 1'b1 && n < 100) begin step(); n++; end
    n_checks++;
    if (n != int'(RST_HOLD + WARMUP) + 1) begin
      n_fail++; $display("FAIL lockloss_rebringup: cycles %0d required %0d", n, RST_HOLD + WARMUP + 1);
    end
  endtask

  task automatic test_resync();
    int n_rst = 0, n_warm = 0;
    int lost_before;
    do_reset();
    pll_locked = 1'b0;
    step();
    bring_up(100);
    pll_locked = 1'b0;
    step();
    bring_up(100);
    lost_before = m_lost;
    resync = 1'b1;
    step();
    resync = 1'b0;
    while (ser_rst === 1'b1 && n_rst < 100) begin n_rst++; step(); end
    while (link_up !== 1'b1 && n_warm < 100) begin n_warm++; step(); end
    n_checks += 3;
    if (n_rst != int'(RST_HOLD)) begin n_fail++; $display("FAIL resync_ser_rst_len: got %0d required %0d", n_rst, RST_HOLD); end
    if (n_warm != int'(WARMUP)) begin n_fail++; $display("FAIL resync_warmup_len: got %0d required %0d", n_warm, WARMUP); end
    if (int'(lock_lost_cnt) != lost_before) begin
      n_fail++; $display("FAIL resync_lost_cnt: got %0d required %0d", lock_lost_cnt, lost_before);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b1;
      step();
      pll_locked = 1'b0;
      step();
      n_checks++;
      if (int'(lock_lost_cnt) != ((i < 255) ? i : 255)) begin
        n_fail++; $display("FAIL saturate_cnt: event %0d got %0d required %0d", i, lock_lost_cnt, (i < 255) ? i : 255);
      end
    end
  endtask

  task automatic test_reset_mid_warmup();
    pll_locked = 1'b1;
    for (int i = 0; i < int'(RST_HOLD) + 3; i++) step();
    n_checks++;
    if (ser_rst !== 1'b0 || link_up !== 1'b0) begin
      n_fail++; $display("FAIL midwarm_precond: ser_rst=%b link_up=%b required 0/0", ser_rst, link_up);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks += 4;
    if (ser_rst !== 1'b1) begin n_fail++; $display("FAIL midwarm_ser_rst: got %b required 1", ser_rst); end
    if (link_up !== 1'b0) begin n_fail++; $display("FAIL midwarm_link_up: got %b required 0", link_up); end
    if (tx_word0 !== CTL0 || tx_word1 !== CTL0 || tx_word2 !== CTL0) begin
      n_fail++; $display("FAIL midwarm_ctl0: tx=%h/%h/%h required %h", tx_word0, tx_word1, tx_word2, CTL0);
    end
    if (lock_lost_cnt !== 8'd0) begin n_fail++; $display("FAIL midwarm_lost_cnt: got %0d required 0", lock_lost_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      pll_locked = ($urandom_range(0, 59) != 0);
      resync     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) de = ~de;
      for (int i = 0; i < 3; i++) enc[i] = 10'($urandom);
      step();
      n_checks += 4;
      if (ser_rst !== (m_phase == P_IDLE || m_phase == P_RST)) begin
        n_fail++; $display("FAIL random_ser_rst: cycle %0d got %b required %b", c, ser_rst, (m_phase <= P_RST));
      end
      if (link_up !== (m_phase == P_RUN)) begin
        n_fail++; $display("FAIL random_link_up: cycle %0d got %b required %b", c, link_up, (m_phase == P_RUN));
      end
      if (tx_word0 !== m_tx[0] || tx_word1 !== m_tx[1] || tx_word2 !== m_tx[2]) begin
        n_fail++;
        $display("FAIL random_tx: cycle %0d got %h/%h/%h required %h/%h/%h",
                 c, tx_word0, tx_word1, tx_word2, m_tx[0], m_tx[1], m_tx[2]);
      end
      if (int'(lock_lost_cnt) != m_lost) begin
        n_fail++; $display("FAIL random_lost_cnt: cycle %0d got %0d required %0d", c, lock_lost_cnt, m_lost);
      end
    end
    rst = 1'b0; resync = 1'b0; de = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      enc[i]  = '0;
      m_tx[i] = CTL0;
    end
    test_reset();
    test_bringup();
    test_de_extend();
    test_lock_loss();
    test_resync();
    test_saturate();
    test_reset_mid_warmup();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
